fifo_wr_ptr_ctrl: RTL and testbench



---
 rtl/fifo_wr_ptr_ctrl_pkg.sv | 26 ++
 rtl/fifo_wr_ptr_ctrl_if.sv | 37 +++
 rtl/fifo_wr_ptr_ctrl_b2g.sv | 11 +
 rtl/fifo_wr_ptr_ctrl.sv | 74 +++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// Shared FIFO helpers: default address width and Gray/full-compare functions
// used by the write-side pointer controller.
package fifo_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 3;
   // Widest pointer the helper functions handle; callers cast down to their width.
   localparam int unsigned MAX_PTR_W      = 32;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [MAX_PTR_W-1:0] gray_to_bin(input logic [MAX_PTR_W-1:0] gray);
      logic [MAX_PTR_W-1:0] bin;
      bin = '0;
      bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
      for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   // Gray pattern of a pointer exactly one lap ahead: top two bits inverted.
   function automatic logic [MAX_PTR_W-1:0] full_compare(input logic [MAX_PTR_W-1:0] gray,
                                                         input int unsigned            ptr_w);
      return gray ^ (MAX_PTR_W'(3) << (ptr_w - 2));
   endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Producer-side handshake and status bundle of the FIFO write-pointer controller.
interface fifo_wr_ptr_ctrl_if #(
   parameter int unsigned ADDR_W = 3
) ();

   logic              W_INC;
   logic [ADDR_W:0]   RD_GRAY_PTR;
   logic              W_EN;
   logic [ADDR_W-1:0] W_ADDR;
   logic [ADDR_W:0]   WR_GRAY_PTR;
   logic              W_FULL;
   logic              W_ALMOST_FULL;
   logic [ADDR_W:0]   W_LEVEL;

   modport master (
      output W_INC,
      output RD_GRAY_PTR,
      input  W_EN,
      input  W_ADDR,
      input  WR_GRAY_PTR,
      input  W_FULL,
      input  W_ALMOST_FULL,
      input  W_LEVEL
   );

   modport slave (
      input  W_INC,
      input  RD_GRAY_PTR,
      output W_EN,
      output W_ADDR,
      output WR_GRAY_PTR,
      output W_FULL,
      output W_ALMOST_FULL,
      output W_LEVEL
   );

endinterface

// File: rtl/fifo_wr_ptr_ctrl_b2g.sv
// Combinational binary-to-Gray converter for an (N+1)-bit pointer.
module bin_to_gray_converter #(
   parameter int unsigned N = 3
) (
   input  logic [N:0] bin_i,
   output logic [N:0] gray_o
);

   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller for an async FIFO: binary/Gray write pointer,
// read-pointer synchronizer, and full / almost-full / level status.
module fifo_wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned AF_THRESH = 6
) (
   input  logic                CLK,
   input  logic                RST,
   fifo_wr_ptr_ctrl_if.slave   wif
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0] wbin_q, wbin_d;
   logic [PTR_W-1:0] wgray_q, wgray_d;
   logic [PTR_W-1:0] rq1_gray_q;
   logic [PTR_W-1:0] rq2_gray_q;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic [PTR_W-1:0] level_q, level_d;
   logic [PTR_W-1:0] rbin_c;
   logic [PTR_W-1:0] full_pat_c;
   logic             w_en_c;

   assign w_en_c = wif.W_INC & ~full_q;

   bin_to_gray_converter #(
      .N (ADDR_W)
   ) u_b2g (
      .bin_i  (wbin_d),
      .gray_o (wgray_d)
   );

   // Next pointer and status, all judged against the synchronized read pointer.
   always_comb begin
      wbin_d     = wbin_q + PTR_W'(w_en_c);
      rbin_c     = PTR_W'(gray_to_bin(MAX_PTR_W'(rq2_gray_q)));
      full_pat_c = PTR_W'(full_compare(MAX_PTR_W'(rq2_gray_q), PTR_W));
      level_d    = wbin_d - rbin_c;
      full_d     = (wgray_d == full_pat_c);
      afull_d    = (level_d >= PTR_W'(AF_THRESH));
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         wbin_q     <= '0;
         wgray_q    <= '0;
         rq1_gray_q <= '0;
         rq2_gray_q <= '0;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         level_q    <= '0;
      end else begin
         wbin_q     <= wbin_d;
         wgray_q    <= wgray_d;
         // Two-flop synchronizer; nothing may sit between the stages.
         rq1_gray_q <= wif.RD_GRAY_PTR;
         rq2_gray_q <= rq1_gray_q;
         full_q     <= full_d;
         afull_q    <= afull_d;
         level_q    <= level_d;
      end
   end

   assign wif.W_EN          = w_en_c;
   assign wif.W_ADDR        = wbin_q[ADDR_W-1:0];
   assign wif.WR_GRAY_PTR   = wgray_q;
   assign wif.W_FULL        = full_q;
   assign wif.W_ALMOST_FULL = afull_q;
   assign wif.W_LEVEL       = level_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Scoreboard bench for fifo_wr_ptr_ctrl: an occupancy-based reference model
// queues expected outputs per cycle and they are compared after each edge.
module tb_fifo_wr_ptr_ctrl;

   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int MASK  = 15;
   localparam int AF    = 6;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_wr_ptr_ctrl_if #(.ADDR_W(AW)) wif ();

   fifo_wr_ptr_ctrl #(
      .ADDR_W    (AW),
      .AF_THRESH (AF)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .wif (wif)
   );

   typedef struct {
      int addr;
      int gray;
      int full;
      int af;
      int level;
   } exp_t;

   exp_t sb[$];

   int   n_vec = 0;
   int   n_err = 0;
   int   m_wbin, m_rq1, m_rq2, m_full, m_level;
   logic [AW:0] prev_gray;
   int   saw_full, saw_wrap;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int g2b(input int g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   function automatic int b2g(input int b);
      return (b ^ (b >> 1)) & MASK;
   endfunction

   // One clock: drive inputs, predict post-edge outputs, compare after the edge.
   task automatic cycle(input bit rst, input bit inc, input int rd_gray,
                        input bit chk_en = 1'b1, input bit chk_1bit = 1'b0);
      exp_t e;
      int   en, wn, occ;
      @(negedge clk);
      rst_n           = rst;
      wif.W_INC       = inc;
      wif.RD_GRAY_PTR = 4'(rd_gray);
      en = (inc && (m_full == 0)) ? 1 : 0;
      #1;
      if (chk_en) check_eq("w_en", 32'(wif.W_EN), 32'(en));
      if (!rst) begin
         m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_level = 0;
         e = '{0, 0, 0, 0, 0};
      end else begin
         wn      = (m_wbin + en) & MASK;
         occ     = (wn - g2b(m_rq2)) & MASK;
         m_rq2   = m_rq1;
         m_rq1   = rd_gray;
         m_full  = (occ == DEPTH) ? 1 : 0;
         m_level = occ;
         m_wbin  = wn;
         e = '{wn & (DEPTH - 1), b2g(wn), m_full, (occ >= AF) ? 1 : 0, occ};
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("w_addr",  32'(wif.W_ADDR),        32'(e.addr));
      check_eq("wr_gray", 32'(wif.WR_GRAY_PTR),   32'(e.gray));
      check_eq("w_full",  32'(wif.W_FULL),        32'(e.full));
      check_eq("w_afull", 32'(wif.W_ALMOST_FULL), 32'(e.af));
      check_eq("w_level", 32'(wif.W_LEVEL),       32'(e.level));
      if (chk_1bit) begin
         check_eq("gray_1bit", 32'($countones(wif.WR_GRAY_PTR ^ prev_gray)), 32'(en));
         if (wif.W_FULL) saw_full = 1;
         if (prev_gray == 4'b1000 && wif.WR_GRAY_PTR == 4'b0000) saw_wrap = 1;
      end
      prev_gray = wif.WR_GRAY_PTR;
   endtask

   initial begin
      int r;
      m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_level = 0;
      prev_gray = '0; saw_full = 0; saw_wrap = 0;
      rst_n = 1'b0; wif.W_INC = 1'b1; wif.RD_GRAY_PTR = '0;

      // Reset held two edges with a pending write
      cycle(1'b0, 1'b1, 0, 1'b0);
      cycle(1'b0, 1'b1, 0);
      check_eq("rst_addr", 32'(wif.W_ADDR), 32'd0);

      // Fill to full from an empty FIFO
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 0);
      check_eq("fill_full", 32'(wif.W_FULL), 32'd1);
      check_eq("fill_gray", 32'(wif.WR_GRAY_PTR), 32'hC);

      // Producer keeps writing while full
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 0);
      check_eq("hold_gray", 32'(wif.WR_GRAY_PTR), 32'hC);
      check_eq("hold_level", 32'(wif.W_LEVEL), 32'd8);

      // One read releases full after the synchronizer delay
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1);
      check_eq("drain_full", 32'(wif.W_FULL), 32'd0);
      check_eq("drain_level", 32'(wif.W_LEVEL), 32'd7);
      cycle(1'b1, 1'b1, 1);
      check_eq("drain_gray", 32'(wif.WR_GRAY_PTR), 32'hD);

      // Read pointer walks up to two behind, then tracks across the wrap
      r = 1;
      for (int i = 0; i < 16 && r != ((m_wbin - 2) & MASK); i++) begin
         r = (r + 1) & MASK;
         cycle(1'b1, 1'b0, b2g(r));
      end
      for (int i = 0; i < 20; i++) begin
         r = (m_wbin - 2) & MASK;
         cycle(1'b1, 1'b1, b2g(r), 1'b1, 1'b1);
      end
      check_eq("wrap_seen", 32'(saw_wrap), 32'd1);
      check_eq("wrap_no_full", 32'(saw_full), 32'd0);

      // Reach level 5 with a frozen read pointer, then reset mid-operation
      for (int i = 0; i < 10 && m_level < 5; i++) cycle(1'b1, 1'b1, b2g(r));
      check_eq("pre_rst_level", 32'(wif.W_LEVEL), 32'd5);
      cycle(1'b0, 1'b1, 0);
      check_eq("midrst_addr", 32'(wif.W_ADDR), 32'd0);
      cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
